hilo_muldiv: RTL

Parametrised successor to the HI/LO register pair. It holds HI and LO and owns the multiply/divide engine that writes them. MULT/MULTU use a fixed-latency multiplier. DIV/DIVU use an iterative radix-2 divider. MTHI/MTLO are single-cycle writes. It sits in the EX stage: it raises `busy` to stall the pipeline, and `exc_oc` cancels any write or in-flight operation.

---
 rtl/hilo_pkg.sv | 27 ++
 rtl/hilo_muldiv_div_iter.sv | 53 +++++
 rtl/hilo_muldiv.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op encodings, FSM states and counter sizing for hilo_muldiv
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Wide enough for the longer of the divide (DW+1 cycles) and multiply latencies.
  function automatic int cnt_width(input int dw, input int mul_lat);
    int top;
    top = (dw + 1 > mul_lat) ? dw + 1 : mul_lat;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// rtl/hilo_muldiv_div_iter.sv - unsigned restoring divider, one quotient bit per cycle
module div_iter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem,
  output logic          valid
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] d;
  logic [CW-1:0] step;
  logic          active;
  logic [DW:0]   sh;
  logic [DW-1:0] diff;
  logic          ge;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign sh    = {rem, quo[DW-1]};
  assign ge    = (sh >= {1'b0, d});
  assign diff  = sh[DW-1:0] - d;
  assign valid = active && (step == CW'(DW));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      quo    <= '0;
      rem    <= '0;
      d      <= '0;
      step   <= '0;
      active <= 1'b0;
    end else if (start) begin
      quo    <= dividend;
      rem    <= '0;
      d      <= divisor;
      step   <= '0;
      active <= 1'b1;
    end else if (abort || valid) begin
      active <= 1'b0;
    end else if (active) begin
      rem  <= ge ? diff : sh[DW-1:0];
      quo  <= {quo[DW-2:0], ge};
      step <= step + CW'(1);
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with pipelined multiplier and iterative divider
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [DW-1:0] srca,
  input  logic [DW-1:0] srcb,
  input  logic          exc_oc,
  input  logic [1:0]    ren,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done
);

  localparam int CW = cnt_width(DW, MUL_LAT);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] hi, lo;
  logic          accept;

  assign accept = op_valid && (state == ST_IDLE) && !exc_oc;
  assign busy   = (state != ST_IDLE);
  assign rdata  = ({DW{ren[1]}} & hi) | ({DW{ren[0]}} & lo);

  // Multiplier: DW+1-bit signed operands, low 2*DW bits of the product are exact.
  logic          mul_signed;
  logic [DW:0]   ma, mb;
  logic [2*DW-1:0] ma_x, mb_x, mprod;
  logic [2*DW-1:0] mpipe [MUL_LAT];

  assign mul_signed = (op == OP_MULT);
  assign ma    = {mul_signed & srca[DW-1], srca};
  assign mb    = {mul_signed & srcb[DW-1], srcb};
  assign ma_x  = {{(DW-1){ma[DW]}}, ma};
  assign mb_x  = {{(DW-1){mb[DW]}}, mb};
  assign mprod = ma_x * mb_x;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mprod;
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  // Divider runs on magnitudes; signs are restored at commit.
  logic          div_signed, a_neg, b_neg, div_start, div_valid;
  logic [DW-1:0] a_abs, b_abs, quo, rem;
  logic          neg_q, neg_r, b_zero;
  logic [DW-1:0] a_raw;

  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & srca[DW-1];
  assign b_neg      = div_signed & srcb[DW-1];
  assign a_abs      = a_neg ? -srca : srca;
  assign b_abs      = b_neg ? -srcb : srcb;
  assign div_start  = accept && ((op == OP_DIV) || (op == OP_DIVU));

  div_iter #(.DW(DW)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .abort    (exc_oc),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo      (quo),
    .rem      (rem),
    .valid    (div_valid)
  );

  logic mul_last, div_last;
  assign mul_last = (state == ST_MUL) && (cnt == CW'(MUL_LAT - 1));
  assign div_last = (state == ST_DIV) && div_valid;
  assign done     = (mul_last || div_last) && !exc_oc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= srca;
              OP_MTLO: lo <= srca;
              OP_MULT, OP_MULTU: begin
                state <= ST_MUL;
                cnt   <= '0;
              end
              OP_DIV, OP_DIVU: begin
                state  <= ST_DIV;
                cnt    <= '0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (srcb == '0);
                a_raw  <= srca;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (exc_oc) begin
            state <= ST_IDLE;
          end else if (mul_last) begin
            {hi, lo} <= mpipe[MUL_LAT-1];
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DIV: begin
          if (exc_oc) begin
            state <= ST_IDLE;
          end else if (div_last) begin
            // Divide by zero is defined: all-ones quotient, dividend as remainder.
            if (b_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= neg_r ? -rem : rem;
              lo <= neg_q ? -quo : quo;
            end
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
